alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised multi-cycle ALU for the datapath; successor to the 16-bit combinational ALU.
//  Keeps the single-cycle logic/arith ops and adds iterative shifts and a shift-add multiply.
//  Adds a valid/ready handshake on both sides, registered flags and a carry flag.
//  Sits between register-read and writeback; control stalls on in_ready/out_valid.
// PARAMETERS
//  WIDTH  16  operand/result width, >=4
//  SHW    4   shift-amount bits = clog2(WIDTH); localparam, not overridable
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous assert, active-low reset
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      block accepts a new operation
//  a          in   WIDTH  operand A, signed
//  b          in   WIDTH  operand B, signed; for shifts b[SHW-1:0] is the amount
//  op         in   4      opcode (see BEHAVIOUR)
//  eq_mode    in   1      1: cond=zero; 0: cond=!zero (BIEQ/BINE select)
//  out_valid  out  1      result and flags valid
//  out_ready  in   1      consumer takes the result
//  result     out  WIDTH  result, signed
//  zero, neg, ovfl, carry, cond, bad_op  out 1 each  flags, registered with result
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1 after release; out_valid=0; result and all flags=0.
//  Reset mid-operation aborts the op. No output appears for it.
//  Opcodes: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 NOR, 6 NAND, 7 SLT (signed),
//           8 SLL, 9 SRL, 10 SRA, 11 MUL (low WIDTH bits), 12-15 illegal.
//  FSM: IDLE -> (in_valid) -> BUSY or DONE; BUSY -> DONE when count==0;
//       DONE -> IDLE on out_ready.
//  in_ready=1 only in IDLE. Accept on in_valid&&in_ready at a clock edge (cycle N).
//  Ops 0-7 and 12-15: IDLE->DONE. out_valid=1 from cycle N+1.
//  Shifts: count loaded with s=b[SHW-1:0]. One bit per BUSY cycle. out_valid from N+s+1.
//    s=0 goes straight to DONE with result=a.
//  MUL: WIDTH shift-add iterations in BUSY. out_valid from N+WIDTH+1.
//  In DONE, result and flags hold stable until out_ready; inputs are ignored.
//    No accept can occur in the cycle the result is popped (in_ready is asserted the cycle after).
//  Arithmetic:
//    ADD: {carry,result}=a+b. SUB and SLT: a+~b+1, carry=carry-out (1 = no borrow).
//    ovfl: ADD = operand signs equal and result sign differs.
//          SUB = operand signs differ and result sign differs from a.
//    SLT: result = (diff_sign ^ ovfl) ? 1 : 0. Its ovfl and carry are reported as 0.
//    SLL, SRL: carry = last bit shifted out (0 if s=0). SRA: sign fill.
//    MUL: signed; ovfl=1 if the upper WIDTH product bits are not the sign-extension of result.
//    Logic ops and shifts: ovfl=0. Logic ops and MUL: carry=0.
//  Flags computed from the final result: zero=(result==0); neg=result[WIDTH-1];
//    cond = eq_mode ? zero : !zero.
//  Illegal op: result=0, bad_op=1, zero=1, other flags 0; completes in 1 cycle.
// STRUCTURE
//  Shared package alu_pkg: opcode localparams (OP_AND..OP_MUL), FSM state encoding, WIDTH default.
//  One sub-module alu_seq_iter: shift/multiply engine with start/done,
//    owning the count and partial-product registers.
//  Top level: FSM, single-cycle combinational ops, flag/output registers.
// TESTING (WIDTH=16)
//  ADD a=16'h7FFF, b=1
//    -> out_valid at N+1, result=16'h8000, ovfl=1, neg=1, carry=0, zero=0.
//  SUB a=5, b=5, eq_mode=0 -> result=0, zero=1, cond=0, carry=1.
//    Same with eq_mode=1 -> cond=1.
//  SLT a=16'h8000, b=1 -> result=1 (correct despite SUB overflow). Swap operands -> result=0.
//  SRA a=16'hF000, b=4 -> out_valid exactly at N+5, result=16'hFF00, carry=0.
//    SLL with b=0 -> result=a at N+1.
//  MUL a=-3, b=7 -> out_valid at N+17, result=16'hFFEB, ovfl=0.
//    a=300, b=300 -> ovfl=1.
//  Hold out_ready=0 for 3 cycles: result stable and in_ready=0.
//    Assert rst_n=0 mid-MUL: outputs zero immediately, in_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and engine modes.
package alu_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        IT_SLL = 2'd0,
        IT_SRL = 2'd1,
        IT_SRA = 2'd2,
        IT_MUL = 2'd3
    } iter_mode_t;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative engine: one-bit-per-cycle shifts and a signed shift-add multiply.
// Outputs are the values the step in progress will produce; done flags the final step.
module alu_seq_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  iter_mode_t                 mode,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [$clog2(WIDTH)-1:0]   amount,
    output logic                       done,
    output logic [WIDTH-1:0]           res,
    output logic                       carry,
    output logic                       ovfl
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MUL  = CW'(WIDTH);

    iter_mode_t         mode_r;
    logic [CW-1:0]      count_r;
    logic [WIDTH-1:0]   sh_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;

    logic               last_s;
    logic [WIDTH-1:0]   sh_nxt_s;
    logic               sh_carry_s;
    logic [2*WIDTH-1:0] acc_nxt_s;

    assign last_s = (count_r == CNT_ONE);

    // Next shift value and the bit leaving the register on this step
    always_comb begin
        sh_nxt_s   = sh_r;
        sh_carry_s = 1'b0;
        case (mode_r)
            IT_SLL: begin
                sh_nxt_s   = {sh_r[WIDTH-2:0], 1'b0};
                sh_carry_s = sh_r[WIDTH-1];
            end
            IT_SRL: begin
                sh_nxt_s   = {1'b0, sh_r[WIDTH-1:1]};
                sh_carry_s = sh_r[0];
            end
            IT_SRA: begin
                sh_nxt_s   = {sh_r[WIDTH-1], sh_r[WIDTH-1:1]};
                sh_carry_s = sh_r[0];
            end
            default: begin
                sh_nxt_s   = sh_r;
                sh_carry_s = 1'b0;
            end
        endcase
    end

    // Partial-product update; the multiplier MSB carries negative weight, so the last step subtracts
    always_comb begin
        acc_nxt_s = acc_r;
        if (mplier_r[0]) begin
            if (last_s) begin
                acc_nxt_s = acc_r - mcand_r;
            end else begin
                acc_nxt_s = acc_r + mcand_r;
            end
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // Engine state: load on start, then one step per cycle until the count drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r   <= IT_SLL;
            count_r  <= CNT_ZERO;
            sh_r     <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
        end else if (start) begin
            mode_r   <= mode;
            count_r  <= (mode == IT_MUL) ? CNT_MUL : CW'(amount);
            sh_r     <= a;
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{a[WIDTH-1]}}, a};
            mplier_r <= b;
        end else if (count_r != CNT_ZERO) begin
            count_r  <= count_r - CNT_ONE;
            sh_r     <= sh_nxt_s;
            acc_r    <= acc_nxt_s;
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
        end
    end

    assign done  = last_s;
    assign res   = (mode_r == IT_MUL) ? acc_nxt_s[WIDTH-1:0] : sh_nxt_s;
    assign carry = (mode_r == IT_MUL) ? 1'b0 : sh_carry_s;
    assign ovfl  = (mode_r == IT_MUL) ?
                   (acc_nxt_s[2*WIDTH-1:WIDTH] != {WIDTH{acc_nxt_s[WIDTH-1]}}) : 1'b0;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready on both sides and registered result/flags.
// Logic/arith ops finish in one cycle; shifts and multiply run in alu_seq_iter.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             eq_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             ovfl,
    output logic             carry,
    output logic             cond,
    output logic             bad_op
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state_r, state_nxt_s;
    iter_mode_t       mode_s;
    logic [SHW-1:0]   amt_s;
    logic             is_shift_s, is_mul_s, need_iter_s, accept_s, capture_s;
    logic             eq_r;

    logic             iter_done_s, iter_carry_s, iter_ovfl_s;
    logic [WIDTH-1:0] iter_res_s;

    logic [WIDTH:0]   sum_s, diff_s;
    logic             add_ovfl_s, sub_ovfl_s;
    logic [WIDTH-1:0] sres_s, fin_res_s;
    logic             scarry_s, sovfl_s, sbad_s;
    logic             fin_carry_s, fin_ovfl_s, fin_bad_s, fin_eq_s, fin_zero_s;

    logic [WIDTH-1:0] result_r;
    logic             zero_r, neg_r, ovfl_r, carry_r, cond_r, bad_op_r;
    logic             in_ready_r, out_valid_r;

    assign amt_s = b[SHW-1:0];

    // Opcode classification and engine mode
    always_comb begin
        is_shift_s = 1'b0;
        is_mul_s   = 1'b0;
        mode_s     = IT_SLL;
        case (op)
            OP_SLL: begin is_shift_s = 1'b1; mode_s = IT_SLL; end
            OP_SRL: begin is_shift_s = 1'b1; mode_s = IT_SRL; end
            OP_SRA: begin is_shift_s = 1'b1; mode_s = IT_SRA; end
            OP_MUL: begin is_mul_s   = 1'b1; mode_s = IT_MUL; end
            default: begin is_shift_s = 1'b0; is_mul_s = 1'b0; end
        endcase
    end

    assign need_iter_s = is_mul_s | (is_shift_s & (amt_s != {SHW{1'b0}}));
    assign accept_s    = (state_r == ST_IDLE) & in_valid;
    assign capture_s   = (accept_s & ~need_iter_s) | ((state_r == ST_BUSY) & iter_done_s);

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept_s & need_iter_s),
        .mode   (mode_s),
        .a      (a),
        .b      (b),
        .amount (amt_s),
        .done   (iter_done_s),
        .res    (iter_res_s),
        .carry  (iter_carry_s),
        .ovfl   (iter_ovfl_s)
    );

    assign sum_s      = {1'b0, a} + {1'b0, b};
    assign diff_s     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign add_ovfl_s = (a[WIDTH-1] == b[WIDTH-1]) & (sum_s[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovfl_s = (a[WIDTH-1] != b[WIDTH-1]) & (diff_s[WIDTH-1] != a[WIDTH-1]);

    // Single-cycle ops; zero-amount shifts pass a through
    always_comb begin
        sres_s   = {WIDTH{1'b0}};
        scarry_s = 1'b0;
        sovfl_s  = 1'b0;
        sbad_s   = 1'b0;
        case (op)
            OP_AND:  sres_s = a & b;
            OP_OR:   sres_s = a | b;
            OP_ADD:  begin sres_s = sum_s[WIDTH-1:0];  scarry_s = sum_s[WIDTH];  sovfl_s = add_ovfl_s; end
            OP_SUB:  begin sres_s = diff_s[WIDTH-1:0]; scarry_s = diff_s[WIDTH]; sovfl_s = sub_ovfl_s; end
            OP_XOR:  sres_s = a ^ b;
            OP_NOR:  sres_s = ~(a | b);
            OP_NAND: sres_s = ~(a & b);
            OP_SLT:  sres_s = {{(WIDTH-1){1'b0}}, diff_s[WIDTH-1] ^ sub_ovfl_s};
            OP_SLL, OP_SRL, OP_SRA: sres_s = a;
            OP_MUL:  sres_s = {WIDTH{1'b0}};
            default: sbad_s = 1'b1;
        endcase
    end

    // Final-value select: engine result while busy, single-cycle result otherwise
    always_comb begin
        fin_res_s   = sres_s;
        fin_carry_s = scarry_s;
        fin_ovfl_s  = sovfl_s;
        fin_bad_s   = sbad_s;
        fin_eq_s    = eq_mode;
        if (state_r == ST_BUSY) begin
            fin_res_s   = iter_res_s;
            fin_carry_s = iter_carry_s;
            fin_ovfl_s  = iter_ovfl_s;
            fin_bad_s   = 1'b0;
            fin_eq_s    = eq_r;
        end else begin
            fin_res_s   = sres_s;
            fin_carry_s = scarry_s;
            fin_ovfl_s  = sovfl_s;
            fin_bad_s   = sbad_s;
            fin_eq_s    = eq_mode;
        end
        fin_zero_s = (fin_res_s == {WIDTH{1'b0}});
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = need_iter_s ? ST_BUSY : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (iter_done_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            eq_r        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
            if (accept_s) begin
                eq_r <= eq_mode;
            end
        end
    end

    // Result and flags, loaded once per operation and held through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b0;
            neg_r    <= 1'b0;
            ovfl_r   <= 1'b0;
            carry_r  <= 1'b0;
            cond_r   <= 1'b0;
            bad_op_r <= 1'b0;
        end else if (capture_s) begin
            result_r <= fin_res_s;
            zero_r   <= fin_zero_s;
            neg_r    <= fin_res_s[WIDTH-1];
            ovfl_r   <= fin_ovfl_s;
            carry_r  <= fin_carry_s;
            cond_r   <= ~fin_bad_s & (fin_eq_s ? fin_zero_s : ~fin_zero_s);
            bad_op_r <= fin_bad_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign neg       = neg_r;
    assign ovfl      = ovfl_r;
    assign carry     = carry_r;
    assign cond      = cond_r;
    assign bad_op    = bad_op_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16): values, latencies, hold and reset abort.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, eq_mode, out_valid, out_ready;
    logic [15:0] a, b, result;
    logic [3:0]  op;
    logic        zero, neg, ovfl, carry, cond, bad_op;

    int n_chk  = 0;
    int n_fail = 0;
    int lat;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .eq_mode(eq_mode),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .neg(neg), .ovfl(ovfl), .carry(carry), .cond(cond), .bad_op(bad_op)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one operation, scramble the inputs after accept, and measure edges until out_valid.
    task automatic issue(input logic [3:0] o, input logic [15:0] aa, input logic [15:0] bb,
                         input logic em, output int l);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("in_ready_before_issue", 32'(in_ready), 32'd1);
        op = o; a = aa; b = bb; eq_mode = em; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; op = 4'd2; eq_mode = ~em;
        l = 1;
        while (!out_valid && l < 40) begin
            @(posedge clk); #1; l++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("pop_out_valid", 32'(out_valid), 32'd0);
        chk("pop_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0; b = 16'h0; op = 4'd0; eq_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_flags", 32'({zero, neg, ovfl, carry, cond, bad_op}), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        issue(4'd2, 16'h7FFF, 16'h0001, 1'b0, lat);
        chk("add_lat", 32'(lat), 32'd1);
        chk("add_result", 32'(result), 32'h8000);
        chk("add_flags_z_n_o_c_b", 32'({zero, neg, ovfl, carry, bad_op}), 32'b01100);
        pop();

        issue(4'd3, 16'd5, 16'd5, 1'b0, lat);
        chk("sub_result", 32'(result), 32'h0);
        chk("sub_zero_cond_carry", 32'({zero, cond, carry, ovfl}), 32'b1010);
        pop();
        issue(4'd3, 16'd5, 16'd5, 1'b1, lat);
        chk("sub_eq_cond", 32'(cond), 32'd1);
        pop();

        issue(4'd7, 16'h8000, 16'h0001, 1'b0, lat);
        chk("slt_neg_pos", 32'(result), 32'h1);
        chk("slt_ovfl_carry", 32'({ovfl, carry}), 32'b00);
        pop();
        issue(4'd7, 16'h0001, 16'h8000, 1'b0, lat);
        chk("slt_pos_neg", 32'(result), 32'h0);
        pop();

        issue(4'd0, 16'hF0F0, 16'hFF00, 1'b0, lat); chk("and", 32'(result), 32'hF000); pop();
        issue(4'd1, 16'hF0F0, 16'hFF00, 1'b0, lat); chk("or", 32'(result), 32'hFFF0); pop();
        issue(4'd4, 16'hF0F0, 16'hFF00, 1'b0, lat); chk("xor", 32'(result), 32'h0FF0); pop();
        issue(4'd5, 16'hF0F0, 16'hFF00, 1'b0, lat); chk("nor", 32'(result), 32'h000F); pop();
        issue(4'd6, 16'hF0F0, 16'hFF00, 1'b0, lat); chk("nand", 32'(result), 32'h0FFF); pop();

        issue(4'd10, 16'hF000, 16'd4, 1'b0, lat);
        chk("sra_lat", 32'(lat), 32'd5);
        chk("sra_result", 32'(result), 32'hFF00);
        chk("sra_carry_neg", 32'({carry, neg}), 32'b01);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold_result", 32'(result), 32'hFF00);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
        end
        pop();

        issue(4'd8, 16'h1234, 16'd0, 1'b0, lat);
        chk("sll0_lat", 32'(lat), 32'd1);
        chk("sll0_result", 32'(result), 32'h1234);
        chk("sll0_carry", 32'(carry), 32'd0);
        pop();
        issue(4'd8, 16'h8001, 16'd1, 1'b0, lat);
        chk("sll1_lat", 32'(lat), 32'd2);
        chk("sll1_result_carry", 32'({carry, result}), 32'h10002);
        pop();
        issue(4'd9, 16'h0003, 16'd2, 1'b0, lat);
        chk("srl_lat", 32'(lat), 32'd3);
        chk("srl_result_carry_zero", 32'({zero, carry, result}), 32'h30000);
        pop();

        issue(4'd11, 16'hFFFD, 16'd7, 1'b0, lat);
        chk("mul_lat", 32'(lat), 32'd17);
        chk("mul_result", 32'(result), 32'hFFEB);
        chk("mul_flags_o_n_c_cond", 32'({ovfl, neg, carry, cond}), 32'b0101);
        pop();
        issue(4'd11, 16'd300, 16'd300, 1'b0, lat);
        chk("mul_ovf_result", 32'(result), 32'h5F90);
        chk("mul_ovf_flag", 32'(ovfl), 32'd1);
        pop();

        issue(4'd13, 16'h1234, 16'h5678, 1'b0, lat);
        chk("bad_lat", 32'(lat), 32'd1);
        chk("bad_result", 32'(result), 32'h0);
        chk("bad_flags_b_z_n_o_c_cond", 32'({bad_op, zero, neg, ovfl, carry, cond}), 32'b110000);
        pop();

        issue(4'd11, 16'd300, 16'd300, 1'b0, lat);
        pop();
        op = 4'd11; a = 16'hFFFD; b = 16'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_result", 32'(result), 32'h0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_flags", 32'({zero, neg, ovfl, carry, cond, bad_op}), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) lat++;
        end
        chk("abort_no_output", 32'(lat), 32'd0);

        issue(4'd2, 16'd2, 16'd3, 1'b0, lat);
        chk("post_reset_add", 32'(result), 32'h5);
        pop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
